// File: rtl/cgra_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_sequencer
// Brief    : Streams (address, data) configuration words onto the CGRA config
//            bus with a fixed hold window and idle gap, waits a settle
//            interval, then times a run of programmed length.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_config_sequencer #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 65
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [CNT_W-1:0]  run_cycles_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    input  logic [ADDR_W-1:0] cfg_addr_in,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic              cfg_last_in,
    output logic [ADDR_W-1:0] config_addr_out,
    output logic [DATA_W-1:0] config_data_out,
    output logic              config_done_out,
    output logic              running_out,
    output logic              done_out,
    output logic [CNT_W-1:0]  cycle_count_out,
    output logic [15:0]       word_count_out,
    output logic              error_out
);

    // Counter widths; a zero settle interval still needs a 1-bit counter.
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int c_SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD   = c_HOLD_W'(HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE    = c_HOLD_W'(1);
    localparam logic [c_SET_W-1:0]  c_SET_ONE     = c_SET_W'(1);
    localparam logic [c_SET_W-1:0]  c_SETTLE_LAST =
        c_SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam bit                  c_HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [CNT_W-1:0]    c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_post_settle;

    logic [c_HOLD_W-1:0] r_hold;
    logic                r_last_pend;
    logic [c_SET_W-1:0]  r_settle;
    logic [CNT_W-1:0]    r_run_cycles;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_data;
    logic                r_config_done;
    logic                r_running;
    logic                r_done;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [15:0]         r_word_count;
    logic                r_error;

    logic                w_ready;
    logic                w_accept;
    logic                w_addr_nz;
    logic                w_start;
    logic                w_hold_end;
    logic                w_load_finish;
    logic                w_settle_end;
    logic                w_run_end;
    logic                w_enter_run;
    logic                w_enter_done;

    // Ready depends only on registered state so upstream sees no input-to-output path.
    assign w_ready   = (r_state == S_LOAD) && (r_hold == '0);
    assign w_accept  = cfg_valid_in && w_ready;
    assign w_addr_nz = |cfg_addr_in;
    assign w_start   = start_in && !abort_in && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The held word leaves the bus after this cycle.
    assign w_hold_end    = (r_state == S_LOAD) && (r_hold == c_HOLD_ONE);
    // Load is complete once the final word has been driven, or dropped for address 0.
    assign w_load_finish = (w_accept && !w_addr_nz && cfg_last_in) || (w_hold_end && r_last_pend);
    assign w_settle_end  = (r_settle == c_SETTLE_LAST);
    assign w_run_end     = ((r_cycle_count + c_CNT_ONE) == r_run_cycles);
    assign w_post_settle = (r_run_cycles == '0) ? S_DONE : S_RUN;

    assign w_enter_run  = (w_next_state == S_RUN)  && (r_state != S_RUN);
    assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);

    // State register.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (abort_in) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        w_next_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_load_finish) begin
                        w_next_state = c_HAS_SETTLE ? S_SETTLE : w_post_settle;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_end) begin
                        w_next_state = w_post_settle;
                    end
                end
                S_RUN: begin
                    if (w_run_end) begin
                        w_next_state = S_DONE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Config bus holding register and hold-window countdown.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_hold      <= '0;
            r_last_pend <= 1'b0;
        end else if (abort_in) begin
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_hold      <= '0;
            r_last_pend <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (w_accept && w_addr_nz) begin
                r_cfg_addr  <= cfg_addr_in;
                r_cfg_data  <= cfg_data_in;
                r_hold      <= c_HOLD_LOAD;
                r_last_pend <= cfg_last_in;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - c_HOLD_ONE;
                if (w_hold_end) begin
                    r_cfg_addr  <= '0;
                    r_cfg_data  <= '0;
                    r_last_pend <= 1'b0;
                end
            end
        end
    end

    // Settle interval counter, restarted whenever the sequencer is outside SETTLE.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_settle <= '0;
        end else if (abort_in || (r_state != S_SETTLE)) begin
            r_settle <= '0;
        end else begin
            r_settle <= r_settle + c_SET_ONE;
        end
    end

    // Run length is latched when a load is started.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_run_cycles <= '0;
        end else if (w_start) begin
            r_run_cycles <= run_cycles_in;
        end
    end

    // Word count and sticky error track the current load; abort leaves them intact.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_word_count <= '0;
            r_error      <= 1'b0;
        end else if (w_start) begin
            r_word_count <= '0;
            r_error      <= 1'b0;
        end else if (!abort_in && w_accept) begin
            if (w_addr_nz) begin
                if (r_word_count != 16'hFFFF) begin
                    r_word_count <= r_word_count + 16'd1;
                end
            end else begin
                r_error <= 1'b1;
            end
        end
    end

    // Run cycle counter; it freezes on abort and after the run completes.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_cycle_count <= '0;
        end else if (w_start || (!abort_in && w_enter_run)) begin
            r_cycle_count <= '0;
        end else if (!abort_in && (r_state == S_RUN)) begin
            r_cycle_count <= r_cycle_count + c_CNT_ONE;
        end
    end

    // Status flags: config-done / running / done.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_config_done <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else if (abort_in || w_start) begin
            r_config_done <= 1'b0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_enter_run) begin
                r_config_done <= 1'b1;
                r_running     <= 1'b1;
            end
            if (w_enter_done) begin
                r_config_done <= 1'b1;
                r_running     <= 1'b0;
                r_done        <= 1'b1;
            end
        end
    end

    assign cfg_ready_out   = w_ready;
    assign config_addr_out = r_cfg_addr;
    assign config_data_out = r_cfg_data;
    assign config_done_out = r_config_done;
    assign running_out     = r_running;
    assign done_out        = r_done;
    assign cycle_count_out = r_cycle_count;
    assign word_count_out  = r_word_count;
    assign error_out       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_cgra_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_config_sequencer
// Brief    : Self-checking bench for cgra_config_sequencer using a
//            timestamp-based reference model of load, settle and run windows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_config_sequencer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int HOLD   = 1;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 65;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              start_in;
    logic              abort_in;
    logic [CNT_W-1:0]  run_cycles_in;
    logic              cfg_valid_in;
    logic              cfg_ready_out;
    logic [ADDR_W-1:0] cfg_addr_in;
    logic [DATA_W-1:0] cfg_data_in;
    logic              cfg_last_in;
    logic [ADDR_W-1:0] config_addr_out;
    logic [DATA_W-1:0] config_data_out;
    logic              config_done_out;
    logic              running_out;
    logic              done_out;
    logic [CNT_W-1:0]  cycle_count_out;
    logic [15:0]       word_count_out;
    logic              error_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [15:0] last_wc;
    logic [64:0] last_cc;
    bit          last_err;

    always #5 clk_in = ~clk_in;

    cgra_config_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
        .run_cycles_in(run_cycles_in), .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
        .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
        .config_addr_out(config_addr_out), .config_data_out(config_data_out),
        .config_done_out(config_done_out), .running_out(running_out), .done_out(done_out),
        .cycle_count_out(cycle_count_out), .word_count_out(word_count_out), .error_out(error_out)
    );

    // One complete load/settle/run sequence of the words in q_addr/q_data.
    // Model: each accepted word at cycle c occupies the bus in c+1..c+HOLD;
    // the final word's last bus cycle L places run start at L+SETTLE+1.
    task automatic run_seq(input string name, input bit bp, input int rc, input int abort_off);
        int n, idx, free_at, b_from, b_until, lc, r0, abort_t, t;
        bit last_seen, finished, drv_valid;
        logic [31:0] b_addr, b_data;
        logic [15:0] wc;
        bit err;
        logic exp_ready, exp_cd, exp_run, exp_done;
        logic [31:0] exp_addr, exp_data;
        logic [64:0] exp_cc;
        n = q_addr.size(); idx = 0; free_at = 1; b_from = -1; b_until = -2;
        b_addr = '0; b_data = '0; last_seen = 0; lc = 0; r0 = 0; abort_t = -1;
        wc = '0; err = 0; finished = 0;
        @(negedge clk_in);
        start_in = 1'b1; abort_in = 1'b0; cfg_valid_in = 1'b0; run_cycles_in = 65'(rc);
        for (t = 1; t <= 800 && !finished; t++) begin
            @(negedge clk_in);
            exp_ready = !last_seen && (t >= free_at);
            exp_addr  = (t >= b_from && t <= b_until) ? b_addr : 32'h0;
            exp_data  = (t >= b_from && t <= b_until) ? b_data : 32'h0;
            exp_cd = 1'b0; exp_run = 1'b0; exp_done = 1'b0; exp_cc = '0;
            if (last_seen && t >= r0) begin
                exp_cd   = 1'b1;
                exp_run  = (t < r0 + rc);
                exp_done = (t >= r0 + rc);
                exp_cc   = (t - r0 < rc) ? 65'(t - r0) : 65'(rc);
            end
            if (abort_t >= 0 && t > abort_t) begin
                exp_ready = 1'b0; exp_addr = '0; exp_data = '0;
                exp_cd = 1'b0; exp_run = 1'b0; exp_done = 1'b0; exp_cc = 65'(abort_off);
            end
            vectors++;
            if (cfg_ready_out !== exp_ready) begin
                miscompares++; $display("FAIL %s ready t=%0d got %b want %b", name, t, cfg_ready_out, exp_ready);
            end
            vectors++;
            if (config_addr_out !== exp_addr || config_data_out !== exp_data) begin
                miscompares++;
                $display("FAIL %s bus t=%0d got %h/%h want %h/%h", name, t,
                         config_addr_out, config_data_out, exp_addr, exp_data);
            end
            vectors++;
            if (config_done_out !== exp_cd) begin
                miscompares++; $display("FAIL %s config_done t=%0d got %b want %b", name, t, config_done_out, exp_cd);
            end
            vectors++;
            if (running_out !== exp_run) begin
                miscompares++; $display("FAIL %s running t=%0d got %b want %b", name, t, running_out, exp_run);
            end
            vectors++;
            if (done_out !== exp_done) begin
                miscompares++; $display("FAIL %s done t=%0d got %b want %b", name, t, done_out, exp_done);
            end
            vectors++;
            if (cycle_count_out !== exp_cc) begin
                miscompares++; $display("FAIL %s cycle_count t=%0d got %0d want %0d", name, t, cycle_count_out, exp_cc);
            end
            vectors++;
            if (word_count_out !== wc) begin
                miscompares++; $display("FAIL %s word_count t=%0d got %0d want %0d", name, t, word_count_out, wc);
            end
            vectors++;
            if (error_out !== err) begin
                miscompares++; $display("FAIL %s error t=%0d got %b want %b", name, t, error_out, err);
            end
            if (abort_t >= 0 && t >= abort_t + 3) finished = 1;
            if (abort_t < 0 && last_seen && t >= r0 + rc + 2) finished = 1;
            // Drive the inputs for this cycle.
            abort_in = 1'b0;
            if (last_seen && abort_off >= 0 && abort_off < rc && t == r0 + abort_off) begin
                abort_in = 1'b1;
                abort_t  = t;
            end
            // Stray starts outside IDLE/DONE must be ignored.
            start_in = (!finished && abort_t < 0 && (!last_seen || t < r0 + rc))
                       ? ($urandom_range(0, 7) == 0) : 1'b0;
            drv_valid = (!last_seen && idx < n) ? (bp ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            cfg_valid_in = drv_valid;
            cfg_addr_in  = drv_valid ? q_addr[idx] : $urandom;
            cfg_data_in  = drv_valid ? q_data[idx] : $urandom;
            cfg_last_in  = drv_valid ? (idx == n - 1) : 1'($urandom_range(0, 1));
            if (drv_valid && exp_ready) begin
                if (q_addr[idx] != 32'h0) begin
                    b_from = t + 1; b_until = t + HOLD; b_addr = q_addr[idx]; b_data = q_data[idx];
                    free_at = t + HOLD + 1; lc = t + HOLD;
                    if (wc != 16'hFFFF) wc = wc + 16'd1;
                end else begin
                    err = 1; free_at = t + 1; lc = t;
                end
                if (idx == n - 1) begin
                    last_seen = 1;
                    r0 = lc + SETTLE + 1;
                end
                idx++;
            end
        end
        if (!finished) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout got last_seen=%0d want sequence complete", name, last_seen);
        end
        start_in = 1'b0; abort_in = 1'b0; cfg_valid_in = 1'b0; cfg_last_in = 1'b0;
        last_wc  = wc;
        last_err = err;
        last_cc  = (abort_t >= 0) ? 65'(abort_off) : 65'(rc);
    endtask

    task automatic test_reset();
        reset_in = 1'b0; start_in = 1'b0; abort_in = 1'b0; run_cycles_in = '0;
        cfg_valid_in = 1'b0; cfg_addr_in = '0; cfg_data_in = '0; cfg_last_in = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if ({cfg_ready_out, config_done_out, running_out, done_out, error_out} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags got %b want 00000",
                {cfg_ready_out, config_done_out, running_out, done_out, error_out});
        end
        vectors++;
        if (config_addr_out !== '0 || config_data_out !== '0 || cycle_count_out !== '0 || word_count_out !== '0) begin
            miscompares++; $display("FAIL reset_values got %h/%h/%0d/%0d want 0/0/0/0",
                config_addr_out, config_data_out, cycle_count_out, word_count_out);
        end
        reset_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_three_words();
        q_addr = '{32'h10, 32'h20, 32'h30};
        q_data = '{32'hAAAA, 32'hBBBB, 32'hCCCC};
        run_seq("three_words", 1'b0, 10, -1);
        vectors++;
        if (word_count_out !== 16'd3) begin
            miscompares++; $display("FAIL three_words_count got %0d want 3", word_count_out);
        end
    endtask

    task automatic test_addr_zero();
        q_addr = '{32'h40, 32'h0, 32'h44};
        q_data = '{32'h1111, 32'h2222, 32'h3333};
        run_seq("addr_zero", 1'b0, 3, -1);
        vectors++;
        if (error_out !== 1'b1 || word_count_out !== 16'd2) begin
            miscompares++; $display("FAIL addr_zero_final got err=%b wc=%0d want err=1 wc=2", error_out, word_count_out);
        end
        // The next load starts with the error cleared.
        q_addr = '{32'h50};
        q_data = '{32'h5555};
        run_seq("error_cleared", 1'b0, 2, -1);
    endtask

    task automatic test_abort_run();
        q_addr = '{32'h60, 32'h64};
        q_data = '{32'h6060, 32'h6464};
        run_seq("abort_run", 1'b0, 9, 4);
        vectors++;
        if (cycle_count_out !== 65'd4 || running_out !== 1'b0) begin
            miscompares++; $display("FAIL abort_hold got cc=%0d run=%b want cc=4 run=0", cycle_count_out, running_out);
        end
    endtask

    task automatic test_start_abort_done();
        q_addr = '{32'h70};
        q_data = '{32'h7070};
        run_seq("pre_done", 1'b0, 3, -1);
        @(negedge clk_in);
        start_in = 1'b1; abort_in = 1'b1; run_cycles_in = 65'd7;
        @(negedge clk_in);
        start_in = 1'b0; abort_in = 1'b0;
        vectors++;
        if (done_out !== 1'b0 || config_done_out !== 1'b0 || cfg_ready_out !== 1'b0) begin
            miscompares++; $display("FAIL start_abort_flags got done=%b cd=%b rdy=%b want 0 0 0",
                done_out, config_done_out, cfg_ready_out);
        end
        vectors++;
        if (cycle_count_out !== last_cc || word_count_out !== last_wc || error_out !== last_err) begin
            miscompares++; $display("FAIL start_abort_hold got cc=%0d wc=%0d err=%b want cc=%0d wc=%0d err=%b",
                cycle_count_out, word_count_out, error_out, last_cc, last_wc, last_err);
        end
        @(negedge clk_in);
        vectors++;
        if (cfg_ready_out !== 1'b0) begin
            miscompares++; $display("FAIL start_abort_idle ready got %b want 0", cfg_ready_out);
        end
    endtask

    task automatic test_backpressure_zero_run();
        q_addr = '{32'h80, 32'h84, 32'h88, 32'h8C};
        q_data = '{32'h8080, 32'h8484, 32'h8888, 32'h8C8C};
        run_seq("bp_zero_run", 1'b1, 0, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 6);
            q_addr.delete();
            q_data.delete();
            for (int k = 0; k < n; k++) begin
                q_addr.push_back(($urandom_range(0, 4) == 0) ? 32'h0 : {$urandom_range(1, 32'hFFFF), 4'h0});
                q_data.push_back($urandom);
            end
            run_seq("random", 1'($urandom_range(0, 1)), $urandom_range(0, 12), -1);
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk_in);
        start_in = 1'b1; run_cycles_in = 65'd5;
        @(negedge clk_in);
        start_in = 1'b0;
        vectors++;
        if (cfg_ready_out !== 1'b1) begin
            miscompares++; $display("FAIL midload_ready got %b want 1", cfg_ready_out);
        end
        cfg_valid_in = 1'b1; cfg_addr_in = 32'h55; cfg_data_in = 32'h1234; cfg_last_in = 1'b0;
        @(negedge clk_in);
        cfg_valid_in = 1'b0;
        vectors++;
        if (config_addr_out !== 32'h55 || config_data_out !== 32'h1234) begin
            miscompares++; $display("FAIL midload_bus got %h/%h want 00000055/00001234", config_addr_out, config_data_out);
        end
        reset_in = 1'b0;
        #1;
        vectors++;
        if (config_addr_out !== '0 || config_data_out !== '0 || word_count_out !== '0 || cycle_count_out !== '0) begin
            miscompares++; $display("FAIL midload_async_bus got %h/%h wc=%0d cc=%0d want 0/0 wc=0 cc=0",
                config_addr_out, config_data_out, word_count_out, cycle_count_out);
        end
        vectors++;
        if ({cfg_ready_out, config_done_out, running_out, done_out, error_out} !== 5'b0) begin
            miscompares++; $display("FAIL midload_async_flags got %b want 00000",
                {cfg_ready_out, config_done_out, running_out, done_out, error_out});
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        vectors++;
        if (cfg_ready_out !== 1'b0 || config_addr_out !== '0) begin
            miscompares++; $display("FAIL midload_idle got rdy=%b addr=%h want 0/0", cfg_ready_out, config_addr_out);
        end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_addr_zero();
        test_abort_run();
        test_start_abort_done();
        test_backpressure_zero_run();
        test_random();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
